sha256_compression_core: RTL and testbench

// - SHA-256 compression stage directly downstream of the message scheduler.
// - Per 512-bit block: runs 64 rounds, consuming one Wt word per round, then adds the working variables a..h into the chaining state H0..H7.
// - Presents the 256-bit digest on a valid/yumi handshake.
// - Holds H across blocks so multi-block messages chain without external storage.
//

---
 rtl/sha256_compression_core.sv | 163 ++++++++++++++++
 tb/tb_sha256_compression_core.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_compression_core.sv
// SHA-256 compression core: 64 iterative rounds plus chaining-state update, digest on valid/yumi.
// Optional block counter output enabled by defining SHA256_BLOCK_COUNT_EN.
module sha256_compression_core #(
    parameter logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
`ifdef SHA256_BLOCK_COUNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         v_i,
    input  logic         first_block_i,
    input  logic [31:0]  wt_i,
    output logic         ready_o,
    output logic         busy_o,
    output logic [5:0]   round_o,
    output logic         v_o,
    output logic [255:0] digest_o,
    input  logic         yumi_i
`ifdef SHA256_BLOCK_COUNT_EN
    , output logic [CNT_W-1:0] block_count_o
`endif
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t       state_q, state_d;
    logic [255:0] h_q;
    logic [31:0]  wa_q, wb_q, wc_q, wd_q, we_q, wf_q, wg_q, wh_q;
    logic [5:0]   round_q;
    logic         accept;
    logic [31:0]  t1, t2;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] k_const(input logic [5:0] r);
        logic [31:0] k;
        case (r)
            6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; default: k = 32'hc67178f2;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        busy_o  = 1'b0;
        v_o     = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (v_i) begin
                    accept  = 1'b1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                busy_o = 1'b1;
                if (round_q == 6'd63) state_d = FINAL;
            end
            FINAL: state_d = DONE;
            default: begin
                v_o = 1'b1;
                if (yumi_i) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        t1 = wh_q + big_s1(we_q) + ch(we_q, wf_q, wg_q) + k_const(round_q) + wt_i;
        t2 = big_s0(wa_q) + maj(wa_q, wb_q, wc_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            h_q     <= IV;
            {wa_q, wb_q, wc_q, wd_q, we_q, wf_q, wg_q, wh_q} <= '0;
            round_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    round_q <= '0;
                    if (first_block_i) begin
                        h_q <= IV;
                        {wa_q, wb_q, wc_q, wd_q, we_q, wf_q, wg_q, wh_q} <= IV;
                    end else begin
                        {wa_q, wb_q, wc_q, wd_q, we_q, wf_q, wg_q, wh_q} <= h_q;
                    end
                end
                ROUND: begin
                    wh_q <= wg_q;
                    wg_q <= wf_q;
                    wf_q <= we_q;
                    we_q <= wd_q + t1;
                    wd_q <= wc_q;
                    wc_q <= wb_q;
                    wb_q <= wa_q;
                    wa_q <= t1 + t2;
                    // 63 + 1 wraps to 0 exactly as the FSM leaves ROUND
                    round_q <= round_q + 6'd1;
                end
                FINAL: h_q <= {h_q[255:224] + wa_q, h_q[223:192] + wb_q, h_q[191:160] + wc_q, h_q[159:128] + wd_q,
                               h_q[127:96]  + we_q, h_q[95:64]   + wf_q, h_q[63:32]   + wg_q, h_q[31:0]    + wh_q};
                default: ;
            endcase
        end
    end

    assign digest_o = h_q;
    assign round_o  = round_q;

`ifdef SHA256_BLOCK_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i)                     cnt_q <= '0;
        else if (accept && first_block_i) cnt_q <= '0;
        else if (state_q == FINAL)       cnt_q <= cnt_q + CNT_W'(1);
    end

    assign block_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_sha256_compression_core.sv
// Scoreboard bench for sha256_compression_core using known SHA-256 test digests.
module tb_sha256_compression_core;

    localparam logic [255:0] IV    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_D = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_D = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] M1_BLK = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] M2_BLK = {480'h0, 32'h000001c0};

    logic         clk_i = 1'b0;
    logic         reset_i, v_i, first_block_i, yumi_i;
    logic [31:0]  wt_i;
    logic         ready_o, busy_o, v_o;
    logic [5:0]   round_o;
    logic [255:0] digest_o;
`ifdef SHA256_BLOCK_COUNT_EN
    logic [31:0]  block_count_o;
`endif

    sha256_compression_core dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .first_block_i(first_block_i), .wt_i(wt_i),
        .ready_o(ready_o), .busy_o(busy_o), .round_o(round_o), .v_o(v_o), .digest_o(digest_o),
        .yumi_i(yumi_i)
`ifdef SHA256_BLOCK_COUNT_EN
        , .block_count_o(block_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    logic [31:0]  wmem [64];
    logic [255:0] exp_q [$];
    bit           chk_q [$];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_schedule(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) wmem[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            wmem[i] = wmem[i-16] + (rotr(wmem[i-15], 7) ^ rotr(wmem[i-15], 18) ^ (wmem[i-15] >> 3))
                    + wmem[i-7] + (rotr(wmem[i-2], 17) ^ rotr(wmem[i-2], 19) ^ (wmem[i-2] >> 10));
    endtask

    task automatic start_block(input logic [511:0] blk, input logic first, input bit push,
                               input bit chk, input logic [255:0] req);
        int n;
        n = 0;
        while (!ready_o && n < 200) begin tick(); n++; end
        check("ready_before_start", 256'(ready_o), 256'(1));
        load_schedule(blk);
        if (push) begin
            exp_q.push_back(req);
            chk_q.push_back(chk);
        end
        v_i = 1'b1;
        first_block_i = first;
        tick();
        v_i = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!v_o && n < 100) begin tick(); n++; end
    endtask

    // Scheduler stand-in: present W[round] for the round currently being executed
    always @(posedge clk_i) begin
        #1;
        wt_i = wmem[round_o];
    end

    always @(negedge clk_i) begin
        if (v_o && yumi_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_digest: actual %h required no output", digest_o);
            end else begin
                logic [255:0] e;
                bit c;
                e = exp_q.pop_front();
                c = chk_q.pop_front();
                if (c) check("digest", digest_o, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit seen_v;
        for (int i = 0; i < 64; i++) wmem[i] = '0;
        reset_i = 1'b1; v_i = 1'b0; first_block_i = 1'b0; yumi_i = 1'b1; wt_i = '0;
        tick();
        tick();
        reset_i = 1'b0;
        check("reset_ready", 256'(ready_o), 256'(1));
        check("reset_busy", 256'(busy_o), 256'(0));
        check("reset_v", 256'(v_o), 256'(0));
        check("reset_round", 256'(round_o), 256'(0));
        check("reset_digest", digest_o, IV);

        // Single-block "abc"
        start_block(ABC_BLK, 1'b1, 1'b1, 1'b1, ABC_D);
        wait_done(n);
        check("abc_latency", 256'(n), 256'(65));
        tick();
        check("abc_ready_after_yumi", 256'(ready_o), 256'(1));

        // Two-block message chained through H
        start_block(M1_BLK, 1'b1, 1'b1, 1'b0, '0);
        wait_done(n);
        check("two_blk1_latency", 256'(n), 256'(65));
        tick();
        start_block(M2_BLK, 1'b0, 1'b1, 1'b1, TWO_D);
        wait_done(n);
        check("two_blk2_latency", 256'(n), 256'(65));
        tick();
`ifdef SHA256_BLOCK_COUNT_EN
        check("block_count_two", 256'(block_count_o), 256'(2));
`endif

        // Back-pressure with stray v_i in ROUND and DONE
        yumi_i = 1'b0;
        start_block(ABC_BLK, 1'b1, 1'b1, 1'b1, ABC_D);
        n = 0;
        while (round_o != 6'd10 && n < 100) begin tick(); n++; end
        check("reach_round10", 256'(round_o), 256'(10));
        v_i = 1'b1;
        tick();
        v_i = 1'b0;
        check("vi_in_round_busy", 256'(busy_o), 256'(1));
        check("vi_in_round_round", 256'(round_o), 256'(11));
        wait_done(n);
        check("bp_reach_done", 256'(v_o), 256'(1));
        for (int i = 0; i < 20; i++) begin
            check("bp_valid_ready", 256'({v_o, ready_o}), 256'(2'b10));
            check("bp_digest", digest_o, ABC_D);
            if (i == 5) v_i = 1'b1;
            tick();
            v_i = 1'b0;
        end
        yumi_i = 1'b1;
        tick();
        check("bp_ready_after_yumi", 256'(ready_o), 256'(1));
        tick();
        check("bp_no_queued_start", 256'(busy_o), 256'(0));
        check("bp_digest_after", digest_o, ABC_D);
`ifdef SHA256_BLOCK_COUNT_EN
        check("block_count_restart", 256'(block_count_o), 256'(1));
`endif

        // Abort a chained block at round 30 via reset
        start_block(ABC_BLK, 1'b0, 1'b0, 1'b0, '0);
        n = 0;
        while (round_o != 6'd30 && n < 100) begin tick(); n++; end
        check("reach_round30", 256'(round_o), 256'(30));
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("abort_ready", 256'(ready_o), 256'(1));
        check("abort_digest", digest_o, IV);
        check("abort_v", 256'(v_o), 256'(0));
        check("abort_busy", 256'(busy_o), 256'(0));
        check("abort_round", 256'(round_o), 256'(0));
        seen_v = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (v_o) seen_v = 1'b1;
            tick();
        end
        check("abort_no_output", 256'(seen_v), 256'(0));

        // Fresh block after abort
        start_block(ABC_BLK, 1'b1, 1'b1, 1'b1, ABC_D);
        wait_done(n);
        check("fresh_latency", 256'(n), 256'(65));
        tick();
        tick();
        check("scoreboard_drained", 256'(exp_q.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
